// File: rtl/npc_pkg.sv
// Shared types and constants for the instruction fetch path.
package npc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_AR    = 3'd1,
        ST_R     = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4
    } fetch_state_e;

    typedef enum logic [1:0] {
        FC_NONE     = 2'd0,
        FC_MISALIGN = 2'd1,
        FC_BUSERR   = 2'd2,
        FC_TIMEOUT  = 2'd3
    } fault_code_e;

    localparam logic [1:0]  AXI_RESP_OKAY    = 2'b00;
    // ecall encoding, so a substituted fault word traps in decode
    localparam logic [31:0] ERR_INST_DEFAULT = 32'h0000_0073;

endpackage

// File: rtl/ifu_axi_fetch.sv
// Single-outstanding AXI4-Lite instruction fetch: PC in, instruction (or fault
// substitute) held toward decode until accepted.
module ifu_axi_fetch
    import npc_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter int              DATA_W   = 32,
    parameter int              TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_INST = ERR_INST_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              fault,
    output logic [1:0]        fault_code,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready
);

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);
    localparam bit         TO_EN  = (TIMEOUT != 0);

    fetch_state_e      state_reg, state_next;
    logic [DATA_W-1:0] inst_reg, inst_next;
    logic [ADDR_W-1:0] inst_pc_reg, inst_pc_next;
    logic [ADDR_W-1:0] araddr_reg, araddr_next;
    fault_code_e       code_reg, code_next;
    logic              fault_reg, fault_next;
    logic              m_valid_reg, m_valid_next;
    logic              arvalid_reg, arvalid_next;
    logic              rready_reg, rready_next;
    logic [7:0]        wait_reg, wait_next;
    logic              ar_to_reg, ar_to_next;
    logic              to_hit;

    assign to_hit = TO_EN && (wait_reg == TO_LIM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            inst_reg    <= '0;
            inst_pc_reg <= '0;
            araddr_reg  <= '0;
            code_reg    <= FC_NONE;
            fault_reg   <= 1'b0;
            m_valid_reg <= 1'b0;
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b0;
            wait_reg    <= '0;
            ar_to_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            inst_reg    <= inst_next;
            inst_pc_reg <= inst_pc_next;
            araddr_reg  <= araddr_next;
            code_reg    <= code_next;
            fault_reg   <= fault_next;
            m_valid_reg <= m_valid_next;
            arvalid_reg <= arvalid_next;
            rready_reg  <= rready_next;
            wait_reg    <= wait_next;
            ar_to_reg   <= ar_to_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        inst_next    = inst_reg;
        inst_pc_next = inst_pc_reg;
        araddr_next  = araddr_reg;
        code_next    = code_reg;
        fault_next   = fault_reg;
        m_valid_next = m_valid_reg;
        arvalid_next = arvalid_reg;
        rready_next  = rready_reg;
        ar_to_next   = ar_to_reg;
        // Saturating wait counter; states that do not wait simply ignore it.
        wait_next    = (wait_reg == 8'hFF) ? wait_reg : wait_reg + 8'd1;

        unique case (state_reg)
            ST_IDLE: begin
                if (s_valid) begin
                    inst_pc_next = pc;
                    if (pc[1:0] != 2'b00) begin
                        inst_next    = ERR_INST;
                        fault_next   = 1'b1;
                        code_next    = FC_MISALIGN;
                        m_valid_next = 1'b1;
                        state_next   = ST_HOLD;
                    end else begin
                        araddr_next  = pc;
                        arvalid_next = 1'b1;
                        wait_next    = '0;
                        ar_to_next   = 1'b0;
                        state_next   = ST_AR;
                    end
                end
            end
            ST_AR: begin
                if (to_hit) ar_to_next = 1'b1;
                if (arready) begin
                    arvalid_next = 1'b0;
                    rready_next  = 1'b1;
                    wait_next    = '0;
                    // A timed-out address phase still owes the slave one R beat.
                    state_next   = (ar_to_reg || to_hit) ? ST_DRAIN : ST_R;
                end
            end
            ST_R: begin
                if (rvalid) begin
                    rready_next  = 1'b0;
                    m_valid_next = 1'b1;
                    state_next   = ST_HOLD;
                    if (rresp != AXI_RESP_OKAY) begin
                        inst_next  = ERR_INST;
                        fault_next = 1'b1;
                        code_next  = FC_BUSERR;
                    end else begin
                        inst_next  = rdata;
                        fault_next = 1'b0;
                        code_next  = FC_NONE;
                    end
                end else if (to_hit) begin
                    rready_next  = 1'b0;
                    inst_next    = ERR_INST;
                    fault_next   = 1'b1;
                    code_next    = FC_TIMEOUT;
                    m_valid_next = 1'b1;
                    state_next   = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                if (rvalid) begin
                    rready_next  = 1'b0;
                    inst_next    = ERR_INST;
                    fault_next   = 1'b1;
                    code_next    = FC_TIMEOUT;
                    m_valid_next = 1'b1;
                    state_next   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (m_ready) begin
                    m_valid_next = 1'b0;
                    state_next   = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign s_ready    = (state_reg == ST_IDLE);
    assign inst       = inst_reg;
    assign inst_pc    = inst_pc_reg;
    assign fault      = fault_reg;
    assign fault_code = code_reg;
    assign m_valid    = m_valid_reg;
    assign araddr     = araddr_reg;
    assign arvalid    = arvalid_reg;
    assign rready     = rready_reg;

endmodule
